// File: rtl/apb_master.sv
// apb_master: turns a valid/ready request port into APB SETUP/ACCESS phases with one-hot PSEL decode.
// Optional macro APB_TIMEOUT_EN aborts an ACCESS phase after TIMEOUT_CYC wait cycles.
module apb_master #(
    parameter int DWIDTH      = 8,
    parameter int AWIDTH      = 8,
    parameter int NSEL        = 4,
    parameter int SELW        = 2,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [AWIDTH-1:0] req_addr,
    input  logic [DWIDTH-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DWIDTH-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [AWIDTH-1:0] PADDR,
    output logic [NSEL-1:0]   PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [DWIDTH-1:0] PWDATA,
    input  logic [DWIDTH-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR,
    output logic [1:0]        state_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

    // Request handshake: a request is taken on an edge where req_valid && req_ready.
    // req_ready is low while a transfer is in flight and during the response cycle.
    state_e          state_q;
    logic [SELW-1:0] idx;
    logic [NSEL-1:0] sel_onehot;
    logic            idx_ok;

`ifdef APB_TIMEOUT_EN
    // The limit edge is the one ending the TIMEOUT_CYC-th wait cycle.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYC - 1);
    logic [7:0] wait_q;
`endif

    assign idx = req_addr[AWIDTH-1 -: SELW];

    always_comb begin
        sel_onehot = '0;
        idx_ok     = 1'b0;
        for (int i = 0; i < NSEL; i++) begin
            if (32'(idx) == i) begin
                sel_onehot[i] = 1'b1;
                idx_ok        = 1'b1;
            end
        end
    end

    assign req_ready = (state_q == IDLE) && !rsp_valid;
    assign state_o   = state_q;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= IDLE;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
`ifdef APB_TIMEOUT_EN
            wait_q    <= '0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            case (state_q)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        PADDR  <= req_addr;
                        PWRITE <= req_write;
                        PWDATA <= req_wdata;
                        if (idx_ok) begin
                            PSEL    <= sel_onehot;
                            state_q <= SETUP;
                        end else begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    state_q <= ACCESS;
`ifdef APB_TIMEOUT_EN
                    wait_q  <= '0;
`endif
                end
                ACCESS: begin
                    if (PREADY) begin
                        PSEL      <= '0;
                        PENABLE   <= 1'b0;
                        state_q   <= IDLE;
                        rsp_valid <= 1'b1;
                        rsp_err   <= PSLVERR;
                        if (!PWRITE && !PSLVERR) rsp_rdata <= PRDATA;
                    end
`ifdef APB_TIMEOUT_EN
                    else if (wait_q == WAIT_LAST) begin
                        PSEL      <= '0;
                        PENABLE   <= 1'b0;
                        state_q   <= IDLE;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                    end else if (wait_q != 8'hFF) begin
                        wait_q <= wait_q + 8'd1;
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master (NSEL=3, TIMEOUT_CYC=4): vector table of transfers plus
// hand sequences for decode error, reset mid-ACCESS and the ACCESS wait limit.
module tb_apb_master;

    logic       PCLK;
    logic       PRESETn;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic [7:0] PADDR;
    logic [2:0] PSEL;
    logic       PENABLE;
    logic       PWRITE;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA;
    logic       PREADY;
    logic       PSLVERR;
    logic [1:0] state_o;

    apb_master #(
        .DWIDTH(8), .AWIDTH(8), .NSEL(3), .SELW(2), .TIMEOUT_CYC(4)
    ) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .state_o(state_o)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic       write;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] prdata;
        logic       slverr;
        int         waits;
        logic [2:0] exp_psel;
        logic [7:0] exp_rdata;
        logic       exp_err;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic run_xfer(input vec_t v, input string tag);
        int lat;
        chk({tag, " req_ready before"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_write = v.write;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        PREADY = 1'b0; PRDATA = 8'h00; PSLVERR = 1'b0;
        tick();
        req_valid = 1'b0;
        req_addr  = 8'($urandom_range(0, 255));
        req_wdata = 8'($urandom_range(0, 255));
        req_write = ~v.write;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            if (rsp_valid) begin
                lat = k;
                break;
            end
            chk({tag, " PSEL"}, 32'(PSEL), 32'(v.exp_psel));
            chk({tag, " PENABLE"}, 32'(PENABLE), (k >= 2) ? 32'd1 : 32'd0);
            chk({tag, " PADDR"}, 32'(PADDR), 32'(v.addr));
            chk({tag, " PWRITE"}, 32'(PWRITE), 32'(v.write));
            if (v.write) chk({tag, " PWDATA"}, 32'(PWDATA), 32'(v.wdata));
            PREADY  = (k >= 2) && (k - 2 == v.waits);
            PRDATA  = (k >= 2) ? v.prdata : 8'h00;
            PSLVERR = (k >= 2) && (k - 2 == v.waits) && v.slverr;
            tick();
        end
        chk({tag, " latency"}, 32'(lat), 32'(3 + v.waits));
        chk({tag, " rsp_err"}, 32'(rsp_err), 32'(v.exp_err));
        chk({tag, " rsp_rdata"}, 32'(rsp_rdata), 32'(v.exp_rdata));
        chk({tag, " PSEL after"}, 32'(PSEL), 32'd0);
        chk({tag, " PENABLE after"}, 32'(PENABLE), 32'd0);
        chk({tag, " req_ready in rsp"}, 32'(req_ready), 32'd0);
        PREADY = 1'b0; PRDATA = 8'h00; PSLVERR = 1'b0;
        tick();
        chk({tag, " rsp_valid one cycle"}, 32'(rsp_valid), 32'd0);
        chk({tag, " req_ready idle"}, 32'(req_ready), 32'd1);
        chk({tag, " PADDR kept"}, 32'(PADDR), 32'(v.addr));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        vecs[0] = '{1'b1, 8'h40, 8'hA5, 8'h00, 1'b0, 0, 3'b010, 8'h00, 1'b0};
        vecs[1] = '{1'b0, 8'h40, 8'h00, 8'hA5, 1'b0, 0, 3'b010, 8'hA5, 1'b0};
        vecs[2] = '{1'b1, 8'h05, 8'h3C, 8'h00, 1'b0, 3, 3'b001, 8'h00, 1'b0};
        vecs[3] = '{1'b0, 8'h8F, 8'h00, 8'h5A, 1'b1, 1, 3'b100, 8'h00, 1'b1};
        vecs[4] = '{1'b0, 8'h81, 8'h00, 8'hC3, 1'b0, 2, 3'b100, 8'hC3, 1'b0};
        vecs[5] = '{1'b1, 8'h7E, 8'h99, 8'h00, 1'b1, 0, 3'b010, 8'h00, 1'b1};
        vecs[6] = '{1'b0, 8'h3F, 8'h00, 8'h6E, 1'b0, 3, 3'b001, 8'h6E, 1'b0};

        PRESETn = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
        PRDATA = 8'h00; PREADY = 1'b0; PSLVERR = 1'b0;
        #12;
        chk("reset PSEL", 32'(PSEL), 32'd0);
        chk("reset PENABLE", 32'(PENABLE), 32'd0);
        chk("reset PWRITE", 32'(PWRITE), 32'd0);
        chk("reset PADDR", 32'(PADDR), 32'd0);
        chk("reset PWDATA", 32'(PWDATA), 32'd0);
        chk("reset rsp", 32'({rsp_valid, rsp_err, rsp_rdata}), 32'd0);
        chk("reset req_ready", 32'(req_ready), 32'd1);
        chk("reset state", 32'(state_o), 32'd0);
        #10;
        PRESETn = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) run_xfer(vecs[i], $sformatf("vec%0d", i));

        // Decode error, then a back-to-back request held through the busy cycle.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'hC0; req_wdata = 8'h00;
        tick();
        chk("decerr PSEL", 32'(PSEL), 32'd0);
        chk("decerr PENABLE", 32'(PENABLE), 32'd0);
        chk("decerr rsp", 32'({rsp_valid, rsp_err, rsp_rdata}), 32'h200 | 32'h100);
        chk("decerr req_ready", 32'(req_ready), 32'd0);
        chk("decerr state", 32'(state_o), 32'd0);
        req_addr = 8'h40; PRDATA = 8'h11; PREADY = 1'b1;
        tick();
        chk("b2b held rsp_valid", 32'(rsp_valid), 32'd0);
        chk("b2b held PSEL", 32'(PSEL), 32'd0);
        chk("b2b held req_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        chk("b2b setup PSEL", 32'(PSEL), 32'b010);
        chk("b2b setup PENABLE", 32'(PENABLE), 32'd0);
        tick();
        chk("b2b access PENABLE", 32'(PENABLE), 32'd1);
        tick();
        chk("b2b rsp", 32'({rsp_valid, rsp_err, rsp_rdata}), 32'h211);
        PREADY = 1'b0; PRDATA = 8'h00;
        tick();

        // Reset asserted in the middle of an ACCESS phase.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h80; req_wdata = 8'h77;
        tick();
        req_valid = 1'b0;
        tick();
        chk("midrst access PENABLE", 32'(PENABLE), 32'd1);
        #2 PRESETn = 1'b0;
        #1;
        chk("midrst PSEL", 32'(PSEL), 32'd0);
        chk("midrst PENABLE", 32'(PENABLE), 32'd0);
        chk("midrst PWRITE", 32'(PWRITE), 32'd0);
        chk("midrst PADDR", 32'(PADDR), 32'd0);
        chk("midrst PWDATA", 32'(PWDATA), 32'd0);
        chk("midrst rsp", 32'({rsp_valid, rsp_err, rsp_rdata}), 32'd0);
        PREADY = 1'b1;
        @(posedge PCLK);
        #2 PRESETn = 1'b1;
        tick();
        chk("postrst req_ready", 32'(req_ready), 32'd1);
        chk("postrst rsp_valid", 32'(rsp_valid), 32'd0);
        tick();
        chk("postrst rsp_valid 2", 32'(rsp_valid), 32'd0);
        chk("postrst PSEL", 32'(PSEL), 32'd0);
        PREADY = 1'b0;

        // Slave that never raises PREADY.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h40; PRDATA = 8'hEE;
        tick();
        req_valid = 1'b0;
`ifdef APB_TIMEOUT_EN
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            if (rsp_valid) begin
                lat = k;
                break;
            end
            tick();
        end
        chk("timeout latency", 32'(lat), 32'd6);
        chk("timeout rsp_err", 32'(rsp_err), 32'd1);
        chk("timeout rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("timeout PSEL", 32'(PSEL), 32'd0);
        chk("timeout PENABLE", 32'(PENABLE), 32'd0);
`else
        lat = 0;
        tick();
        for (int k = 0; k < 55; k++) begin
            chk("stall hold", 32'({rsp_valid, PENABLE, PSEL}), 32'b01010);
            tick();
        end
        PREADY = 1'b1;
        tick();
        chk("stall release rsp", 32'({rsp_valid, rsp_err, rsp_rdata}), 32'h2EE);
        chk("stall release PSEL", 32'(PSEL), 32'd0);
`endif
        PREADY = 1'b0; PRDATA = 8'h00;
        tick();
        chk("final req_ready", 32'(req_ready), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- Upstream APB requester/bridge that drives the peripheral register slaves: turns a simple valid/ready request port into APB SETUP/ACCESS phases and returns a registered one-cycle response.
- Decodes the upper address bits into one-hot PSEL lines, one per slave. PRDATA, PREADY and PSLVERR arrive already muxed/ORed from the slaves; unselected slaves drive PRDATA to 0.

Parameters:
- DWIDTH, 8, data width of PWDATA/PRDATA/req_wdata/rsp_rdata
- AWIDTH, 8, address width of req_addr/PADDR
- NSEL, 4, number of slave select lines (1..2**SELW)
- SELW, 2, number of upper address bits used for slave decode
- TIMEOUT_CYC, 16, ACCESS-phase wait limit; used only with APB_TIMEOUT_EN

Ports:
- PCLK  input  1  bus clock; all logic rising-edge
- PRESETn  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  master can accept a request
- req_write  input  1  1=write, 0=read
- req_addr  input  AWIDTH  request address
- req_wdata  input  DWIDTH  write data
- rsp_valid  output  1  one-cycle response strobe
- rsp_rdata  output  DWIDTH  read data; 0 for writes and errors
- rsp_err  output  1  decode error, PSLVERR, or timeout
- PADDR  output  AWIDTH  APB address
- PSEL  output  NSEL  one-hot slave select
- PENABLE  output  1  APB access phase
- PWRITE  output  1  APB direction
- PWDATA  output  DWIDTH  APB write data
- PRDATA  input  DWIDTH  muxed read data
- PREADY  input  1  slave ready; tie high for zero-wait slaves
- PSLVERR  input  1  slave error, sampled with PREADY

Behaviour:
- Reset (async, PRESETn=0): state IDLE; PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0. Reset mid-transfer abandons the transfer with no response.
- All outputs are registered. req_ready = (state==IDLE) && !rsp_valid. This enforces at least one idle cycle between transfers.
- IDLE:
  - On req_valid && req_ready, latch addr/write/wdata into PADDR/PWRITE/PWDATA.
  - idx = req_addr[AWIDTH-1 -: SELW].
  - If idx < NSEL: next state SETUP, PSEL[idx]=1, PENABLE=0.
  - Else: no bus activity; next cycle rsp_valid=1, rsp_err=1, rsp_rdata=0; stay IDLE.
- SETUP (exactly 1 cycle): PENABLE goes 1 at the next edge; state ACCESS.
- ACCESS:
  - While PREADY=0, hold PSEL/PENABLE/PADDR/PWRITE/PWDATA stable.
  - On PREADY=1 at the edge: PSEL=0, PENABLE=0, state IDLE. In the same edge, rsp_valid=1 for one cycle, rsp_err=PSLVERR, rsp_rdata = (!PWRITE && !PSLVERR) ? PRDATA : 0.
- PADDR/PWRITE/PWDATA keep their last values in IDLE; they are not cleared.
- Latency with zero wait states: accept edge -> SETUP -> ACCESS -> rsp_valid asserted 3 cycles after accept, PSEL high for 2 cycles. Each PREADY=0 cycle adds 1 cycle.
- req_valid is ignored when req_ready=0; the requester holds it.
- PSEL is never multi-hot. PENABLE=1 only while some PSEL bit=1.

Optional Feature:
- Macro APB_TIMEOUT_EN.
- Defined: an 8-bit saturating wait counter clears on entering ACCESS and increments each ACCESS cycle with PREADY=0. When it reaches TIMEOUT_CYC with PREADY still 0, the transfer aborts: PSEL=0, PENABLE=0, state IDLE, rsp_valid=1, rsp_err=1, rsp_rdata=0. PREADY=1 on the same edge as the limit wins (normal completion).
- Not defined: no counter; ACCESS waits indefinitely and TIMEOUT_CYC is unused.

Test Plan:
- Reset then write: req addr=0x40 (idx1), wdata=0xA5, PREADY=1 -> PSEL=4'b0010 for 2 cycles, PENABLE on the 2nd cycle, PWDATA=0xA5 stable throughout; rsp_valid pulses 3 cycles after accept with rsp_err=0, rsp_rdata=0x00.
- Read: req addr=0x40, slave PRDATA=0xA5 during ACCESS -> rsp_rdata=0xA5, rsp_err=0, PWRITE=0 for the whole transfer.
- Wait states: PREADY low for 3 ACCESS cycles -> PSEL/PENABLE/PADDR stable 5 cycles total; rsp_valid 6 cycles after accept. Also check PSLVERR=1 with PREADY -> rsp_err=1, rsp_rdata=0.
- Decode error: NSEL=3, addr=0xC0 (idx3) -> PSEL stays 0, PENABLE stays 0, next-cycle rsp_valid=1 with rsp_err=1; back-to-back req_valid sees req_ready=0 for 1 cycle.
- Reset mid-ACCESS: assert PRESETn=0 during ACCESS -> all outputs 0 immediately (async); no rsp_valid after release; req_ready=1 on the first cycle after release.
- With APB_TIMEOUT_EN, TIMEOUT_CYC=4, PREADY held 0 -> abort after 4 ACCESS wait cycles with rsp_err=1; without the macro, the same stimulus keeps PENABLE=1 for 50+ cycles.
